// File: rtl/index_arbiter.sv
// index_arbiter
// -------------
// Round-robin write-port arbiter and read-modify-write sequencer for the
// index register file. Two requesters (A and B) ask for load, increment,
// decrement or clear of one index register. One request is granted at a
// time. The block reads the old value through the file's combinational read
// port and computes the new value. It then commits the new value through the
// file's write port and pulses the granted requester's ACK.
//
// Parameters:
//   AW  index register address width (file depth 2**AW)
//   DW  index register data width
//
// Ports:
//   CLK              clock, rising edge
//   RST_N            asynchronous active-low reset
//   REQ_A / REQ_B    operation request, held until ACK
//   OP_A / OP_B      00 load, 01 increment, 10 decrement, 11 clear
//   ADDR_A / ADDR_B  target index register
//   DATA_A / DATA_B  load operand
//   ACK_A / ACK_B    one-cycle completion pulse
//   RESULT           value being written, valid while an ACK is high
//   BUSY             high while an operation is in flight (READ, WRITE)
//   RF_R_ADDR        file read address (non-zero only in READ)
//   RF_R_DATA        file read data (combinational)
//   RF_S             file write enable
//   RF_W_ADDR        file write address
//   RF_W_DATA        file write data
//
// Configuration:
//   INDEX_ARB_SAT_EN  when defined, increment and decrement saturate at the
//                     ends of the DW-bit range. When it is undefined, they
//                     wrap modulo 2**DW.

module index_arbiter #(
    parameter int AW = 4,
    parameter int DW = 4
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          REQ_A,
    input  logic [1:0]    OP_A,
    input  logic [AW-1:0] ADDR_A,
    input  logic [DW-1:0] DATA_A,
    input  logic          REQ_B,
    input  logic [1:0]    OP_B,
    input  logic [AW-1:0] ADDR_B,
    input  logic [DW-1:0] DATA_B,
    output logic          ACK_A,
    output logic          ACK_B,
    output logic [DW-1:0] RESULT,
    output logic          BUSY,
    output logic [AW-1:0] RF_R_ADDR,
    input  logic [DW-1:0] RF_R_DATA,
    output logic          RF_S,
    output logic [AW-1:0] RF_W_ADDR,
    output logic [DW-1:0] RF_W_DATA
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_INC  = 2'b01;
    localparam logic [1:0] OP_DEC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    localparam logic [DW-1:0] DATA_MAX = '1;
    localparam logic [DW-1:0] DATA_ONE = DW'(1);

    state_t        state;
    logic          ptr_b;      // priority pointer: 0 favours A, 1 favours B
    logic          grant_b;    // the requester currently being served
    logic [1:0]    op_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] data_q;
    logic          win_b;
    logic [DW-1:0] new_value;

    // B wins only when A is idle or when the pointer favours B.
    assign win_b = REQ_B && (!REQ_A || ptr_b);

    // New value from the latched operation and the old value on the read
    // port. This value is only used at the end of the READ cycle.
    always_comb begin
        new_value = data_q;
        case (op_q)
            OP_LOAD: new_value = data_q;
`ifdef INDEX_ARB_SAT_EN
            OP_INC:  new_value = (RF_R_DATA == DATA_MAX) ? DATA_MAX : RF_R_DATA + DATA_ONE;
            OP_DEC:  new_value = (RF_R_DATA == '0) ? '0 : RF_R_DATA - DATA_ONE;
`else
            OP_INC:  new_value = RF_R_DATA + DATA_ONE;
            OP_DEC:  new_value = RF_R_DATA - DATA_ONE;
`endif
            OP_CLR:  new_value = '0;
            default: new_value = '0;
        endcase
    end

    // Sequencer. Every output is registered, so nothing combinational runs
    // from REQ to the outputs. Reset abandons any operation in flight
    // without a write or an ACK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= IDLE;
            ptr_b     <= 1'b0;
            grant_b   <= 1'b0;
            op_q      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            ACK_A     <= 1'b0;
            ACK_B     <= 1'b0;
            RESULT    <= '0;
            BUSY      <= 1'b0;
            RF_R_ADDR <= '0;
            RF_S      <= 1'b0;
            RF_W_ADDR <= '0;
            RF_W_DATA <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (REQ_A || REQ_B) begin
                        grant_b   <= win_b;
                        op_q      <= win_b ? OP_B   : OP_A;
                        addr_q    <= win_b ? ADDR_B : ADDR_A;
                        data_q    <= win_b ? DATA_B : DATA_A;
                        RF_R_ADDR <= win_b ? ADDR_B : ADDR_A;
                        BUSY      <= 1'b1;
                        state     <= READ;
                    end
                end
                READ: begin
                    RF_R_ADDR <= '0;
                    RF_S      <= 1'b1;
                    RF_W_ADDR <= addr_q;
                    RF_W_DATA <= new_value;
                    RESULT    <= new_value;
                    ACK_A     <= !grant_b;
                    ACK_B     <= grant_b;
                    state     <= WRITE;
                end
                WRITE: begin
                    // The write has committed, so the other requester gets
                    // priority for the next operation.
                    ptr_b     <= !grant_b;
                    RF_S      <= 1'b0;
                    RF_W_ADDR <= '0;
                    RF_W_DATA <= '0;
                    RESULT    <= '0;
                    ACK_A     <= 1'b0;
                    ACK_B     <= 1'b0;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_index_arbiter.sv
// tb_index_arbiter
// ----------------
// Testbench for index_arbiter. It contains a behavioural index register file
// that the DUT writes through its RF_* port. Expected values come from a
// reference model: an array holding the register contents, a round-robin
// owner variable, and arithmetic for each operation.

module tb_index_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 4;
    localparam int MAXV = (1 << DW) - 1;

    logic          CLK;
    logic          RST_N;
    logic          REQ_A, REQ_B;
    logic [1:0]    OP_A, OP_B;
    logic [AW-1:0] ADDR_A, ADDR_B;
    logic [DW-1:0] DATA_A, DATA_B;
    logic          ACK_A, ACK_B;
    logic [DW-1:0] RESULT;
    logic          BUSY;
    logic [AW-1:0] RF_R_ADDR;
    logic [DW-1:0] RF_R_DATA;
    logic          RF_S;
    logic [AW-1:0] RF_W_ADDR;
    logic [DW-1:0] RF_W_DATA;

    // The bench uses this port to preload the register file while the DUT is idle.
    logic          pre_en;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;

    logic [DW-1:0] rf_mem [1 << AW];

    int checks   = 0;
    int failures = 0;
    int ref_mem [1 << AW];
    int ref_ptr;               // 0: A has priority, 1: B has priority

    index_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .REQ_A     (REQ_A),
        .OP_A      (OP_A),
        .ADDR_A    (ADDR_A),
        .DATA_A    (DATA_A),
        .REQ_B     (REQ_B),
        .OP_B      (OP_B),
        .ADDR_B    (ADDR_B),
        .DATA_B    (DATA_B),
        .ACK_A     (ACK_A),
        .ACK_B     (ACK_B),
        .RESULT    (RESULT),
        .BUSY      (BUSY),
        .RF_R_ADDR (RF_R_ADDR),
        .RF_R_DATA (RF_R_DATA),
        .RF_S      (RF_S),
        .RF_W_ADDR (RF_W_ADDR),
        .RF_W_DATA (RF_W_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // The register file has a combinational read and a clocked write.
    assign RF_R_DATA = rf_mem[RF_R_ADDR];

    always @(posedge CLK) begin
        if (pre_en)
            rf_mem[pre_addr] <= pre_data;
        else if (RF_S)
            rf_mem[RF_W_ADDR] <= RF_W_DATA;
    end

    // Reference model: the value each operation should produce.
    function automatic int modelNext(input int op, input int old, input int data);
        case (op)
            0: return data;
`ifdef INDEX_ARB_SAT_EN
            1: return (old == MAXV) ? MAXV : old + 1;
            2: return (old == 0) ? 0 : old - 1;
`else
            1: return (old + 1) % (MAXV + 1);
            2: return (old + MAXV) % (MAXV + 1);
`endif
            default: return 0;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ra, input int oa, input int aa, input int da,
                                 input logic rb, input int ob, input int ab, input int db);
        REQ_A  = ra;
        OP_A   = 2'(oa);
        ADDR_A = AW'(aa);
        DATA_A = DW'(da);
        REQ_B  = rb;
        OP_B   = 2'(ob);
        ADDR_B = AW'(ab);
        DATA_B = DW'(db);
    endtask

    task automatic preload(input int addr, input int data);
        pre_en   = 1'b1;
        pre_addr = AW'(addr);
        pre_data = DW'(data);
        @(negedge CLK);
        pre_en   = 1'b0;
        ref_mem[addr] = data;
    endtask

    // Runs one operation from one requester, with the other requester idle,
    // and checks the READ cycle, the WRITE/ACK cycle and the return to IDLE.
    task automatic runSingle(input bit use_b, input int op, input int addr,
                             input int data, input string tag);
        int expv;
        applyStimulus(!use_b, op, addr, data, use_b, op, addr, data);
        @(negedge CLK);
        checkOutput({tag, "_busy_read"}, BUSY, 1);
        checkOutput({tag, "_raddr"}, RF_R_ADDR, addr);
        checkOutput({tag, "_rfs_read"}, RF_S, 0);
        checkOutput({tag, "_ack_early"}, ACK_A | ACK_B, 0);
        @(negedge CLK);
        expv = modelNext(op, ref_mem[addr], data);
        checkOutput({tag, "_ack_a"}, ACK_A, !use_b);
        checkOutput({tag, "_ack_b"}, ACK_B, use_b);
        checkOutput({tag, "_rfs"}, RF_S, 1);
        checkOutput({tag, "_waddr"}, RF_W_ADDR, addr);
        checkOutput({tag, "_wdata"}, RF_W_DATA, expv);
        checkOutput({tag, "_result"}, RESULT, expv);
        checkOutput({tag, "_busy_write"}, BUSY, 1);
        checkOutput({tag, "_raddr_zero"}, RF_R_ADDR, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        ref_mem[addr] = expv;
        ref_ptr = use_b ? 0 : 1;
        @(negedge CLK);
        checkOutput({tag, "_idle_ack"}, ACK_A | ACK_B, 0);
        checkOutput({tag, "_idle_rfs"}, RF_S, 0);
        checkOutput({tag, "_idle_busy"}, BUSY, 0);
        checkOutput({tag, "_idle_result"}, RESULT, 0);
        checkOutput({tag, "_file"}, rf_mem[addr], ref_mem[addr]);
    endtask

    initial begin
        int expv;
        int waited;
        int winner;
        bit got;

        pre_en   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        RST_N    = 1'b0;
        ref_ptr  = 0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset state.
        @(negedge CLK);
        @(negedge CLK);
        checkOutput("rst_ack_a", ACK_A, 0);
        checkOutput("rst_ack_b", ACK_B, 0);
        checkOutput("rst_busy", BUSY, 0);
        checkOutput("rst_rfs", RF_S, 0);
        checkOutput("rst_result", RESULT, 0);
        checkOutput("rst_raddr", RF_R_ADDR, 0);
        checkOutput("rst_waddr", RF_W_ADDR, 0);
        checkOutput("rst_wdata", RF_W_DATA, 0);
        RST_N = 1'b1;

        // Fill the file with known random contents.
        for (int i = 0; i < (1 << AW); i++)
            preload(i, int'($urandom_range(0, MAXV)));

        // A loads 9 into register 3.
        runSingle(0, 0, 3, 9, "load");
        checkOutput("load_file3", rf_mem[3], 9);

        // Increment and decrement at the ends of the range.
        preload(5, 15);
        runSingle(1, 1, 5, 0, "inc_top");
        preload(5, 0);
        runSingle(1, 2, 5, 0, "dec_bot");

        // Both requesters hold increment requests on register 2 continuously.
        preload(2, 0);
        applyStimulus(1, 1, 2, 0, 1, 1, 2, 0);
        for (int n = 0; n < 4; n++) begin
            got = 0;
            waited = 0;
            while (!got && waited < 8) begin
                @(negedge CLK);
                waited++;
                if (ACK_A || ACK_B) got = 1;
            end
            checkOutput("rr_ack_seen", got, 1);
            if (got) begin
                winner = ACK_B ? 1 : 0;
                expv = modelNext(1, ref_mem[2], 0);
                checkOutput("rr_winner", winner, ref_ptr);
                checkOutput("rr_both_ack", ACK_A & ACK_B, 0);
                checkOutput("rr_result", RESULT, expv);
                if (n > 0) checkOutput("rr_spacing", waited, 3);
                ref_mem[2] = expv;
                ref_ptr = 1 - ref_ptr;
            end
            if (n == 3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        end
        @(negedge CLK);
        checkOutput("rr_file2", rf_mem[2], ref_mem[2]);

        // Changing A's fields after the grant has no effect.
        preload(4, 1);
        preload(7, 5);
        applyStimulus(1, 0, 4, 10, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("chg_busy", BUSY, 1);
        applyStimulus(1, 0, 7, 3, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("chg_ack_a", ACK_A, 1);
        checkOutput("chg_waddr", RF_W_ADDR, 4);
        checkOutput("chg_result", RESULT, modelNext(0, ref_mem[4], 10));
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        ref_mem[4] = 10;
        ref_ptr = 1;
        @(negedge CLK);
        checkOutput("chg_file4", rf_mem[4], ref_mem[4]);
        checkOutput("chg_file7", rf_mem[7], ref_mem[7]);

        // Reset during READ aborts the load, and priority returns to A.
        preload(1, 2);
        applyStimulus(1, 0, 1, 6, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("abort_busy", BUSY, 1);
        #1 RST_N = 1'b0;
        #1;
        checkOutput("abort_busy_rst", BUSY, 0);
        checkOutput("abort_rfs_rst", RF_S, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge CLK);
        checkOutput("abort_ack", ACK_A | ACK_B, 0);
        checkOutput("abort_rfs", RF_S, 0);
        checkOutput("abort_file1", rf_mem[1], ref_mem[1]);
        RST_N = 1'b1;
        ref_ptr = 0;
        applyStimulus(1, 0, 9, 4, 1, 0, 10, 5);
        got = 0;
        waited = 0;
        while (!got && waited < 8) begin
            @(negedge CLK);
            waited++;
            if (ACK_A || ACK_B) got = 1;
        end
        checkOutput("post_rst_ack_seen", got, 1);
        checkOutput("post_rst_ack_a", ACK_A, ref_ptr == 0);
        checkOutput("post_rst_ack_b", ACK_B, ref_ptr == 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        ref_mem[9] = 4;
        ref_ptr = 1;
        @(negedge CLK);
        checkOutput("post_rst_file9", rf_mem[9], ref_mem[9]);
        checkOutput("post_rst_file10", rf_mem[10], ref_mem[10]);

        // A clears register 8, which holds 12.
        preload(8, 12);
        runSingle(0, 3, 8, 0, "clr");

        // Random single operations.
        for (int i = 0; i < 20; i++)
            runSingle(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, (1 << AW) - 1)),
                      int'($urandom_range(0, MAXV)), "rnd");

        // The file must match the model everywhere.
        for (int i = 0; i < (1 << AW); i++)
            checkOutput("final_file", rf_mem[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
